// File: rtl/nnrv_dump_pkg.sv
// Shared definitions for the nnrv_dump state-dump engine: FSM encoding and
// default frame parameters.
package nnrv_dump_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_RD   = 3'd2,
      ST_WAIT = 3'd3,
      ST_SEND = 3'd4,
      ST_TRL  = 3'd5,
      ST_DONE = 3'd6
   } state_e;

   localparam int unsigned NUM_REGS_DEF  = 32;
   localparam int unsigned RAM_WORDS_DEF = 32;
   localparam int unsigned RAM_AW_DEF    = 8;
   localparam logic [7:0]  HDR_BYTE_DEF  = 8'hA5;
   localparam logic [7:0]  TRL_BYTE_DEF  = 8'h5A;

endpackage

// File: rtl/nnrv_dump_if.sv
// Byte stream valid/ready link from the dump engine to the UART transmitter.
//   tx_data  : byte to transmit (master -> slave)
//   tx_valid : tx_data valid    (master -> slave)
//   tx_ready : sink accepts     (slave -> master)
interface nnrv_dump_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/nnrv_dump.sv
// Post-run state dump engine. On a start pulse it reads the register file and
// then the data RAM, serialises each 32-bit word MSB-first and streams the
// bytes, framed by a header and trailer marker, over a valid/ready link.
//   i_clk, i_rst        : clock, asynchronous active-low reset
//   i_start             : single-cycle dump request (honoured only in IDLE)
//   o_busy / o_done     : frame in progress / one-cycle completion pulse
//   o_reg_addr/i_reg_data : register-file read port, 1-cycle latency
//   o_ram_addr/i_ram_data : data-RAM read port, 1-cycle latency
//   tx                  : byte stream master
module nnrv_dump
   import nnrv_dump_pkg::*;
#(
   parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
   parameter int unsigned RAM_WORDS = RAM_WORDS_DEF,
   parameter int unsigned RAM_AW    = RAM_AW_DEF,
   parameter logic [7:0]  HDR_BYTE  = HDR_BYTE_DEF,
   parameter logic [7:0]  TRL_BYTE  = TRL_BYTE_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic [4:0]        o_reg_addr,
   input  logic [31:0]       i_reg_data,
   output logic [RAM_AW-1:0] o_ram_addr,
   input  logic [31:0]       i_ram_data,
   nnrv_dump_if.master       tx
);

   localparam int unsigned NUM_WORDS = NUM_REGS + RAM_WORDS;
   // One spare bit so the index never wraps before the final compare.
   localparam int unsigned WW        = $clog2(NUM_WORDS) + 1;
   localparam logic [WW-1:0] LAST_W  = WW'(NUM_WORDS - 1);
   localparam logic [WW-1:0] REGS_W  = WW'(NUM_REGS);

   state_e        state_q;
   logic [WW-1:0] w_q;
   logic [WW-1:0] w_d;
   logic [1:0]    bcnt_q;
   logic [31:0]   shreg_q;
   logic          xfer_c;

   assign xfer_c = tx.tx_valid && tx.tx_ready;

   // Word index the next RD state will address: current word when leaving HDR,
   // the following word when leaving SEND.
   always_comb begin
      w_d = w_q;
      if (state_q == ST_SEND) begin
         w_d = w_q + WW'(1);
      end
   end

   // Single FSM process; every output is a register updated on the transition
   // into the state where it must be visible.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= ST_IDLE;
         w_q         <= '0;
         bcnt_q      <= '0;
         shreg_q     <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_reg_addr  <= '0;
         o_ram_addr  <= '0;
         tx.tx_data  <= '0;
         tx.tx_valid <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  state_q     <= ST_HDR;
                  w_q         <= '0;
                  o_busy      <= 1'b1;
                  tx.tx_valid <= 1'b1;
                  tx.tx_data  <= HDR_BYTE;
               end
            end
            ST_HDR, ST_SEND: begin
               if (xfer_c) begin
                  if (state_q == ST_SEND && bcnt_q != 2'd3) begin
                     shreg_q    <= shreg_q << 8;
                     bcnt_q     <= bcnt_q + 2'd1;
                     tx.tx_data <= shreg_q[23:16];
                  end else if (state_q == ST_SEND && w_q == LAST_W) begin
                     state_q    <= ST_TRL;
                     tx.tx_data <= TRL_BYTE;
                  end else begin
                     // Next word: present its address during RD and WAIT.
                     state_q     <= ST_RD;
                     w_q         <= w_d;
                     tx.tx_valid <= 1'b0;
                     if (w_d < REGS_W) begin
                        o_reg_addr <= 5'(w_d);
                     end else begin
                        o_ram_addr <= RAM_AW'(w_d - REGS_W);
                     end
                  end
               end
            end
            ST_RD: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               // Read data arrives one cycle after the address, i.e. now.
               state_q     <= ST_SEND;
               bcnt_q      <= '0;
               shreg_q     <= (w_q < REGS_W) ? i_reg_data : i_ram_data;
               tx.tx_data  <= (w_q < REGS_W) ? i_reg_data[31:24] : i_ram_data[31:24];
               tx.tx_valid <= 1'b1;
            end
            ST_TRL: begin
               if (xfer_c) begin
                  state_q     <= ST_DONE;
                  tx.tx_valid <= 1'b0;
                  o_busy      <= 1'b0;
                  o_done      <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               o_done  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nnrv_dump.sv
// Directed self-checking bench for nnrv_dump with a 1-cycle-latency
// register/RAM model and a byte-stream monitor.
module tb_nnrv_dump;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done;
   logic [4:0]  reg_addr;
   logic [7:0]  ram_addr;
   logic [31:0] reg_rdata = '0;
   logic [31:0] ram_rdata = '0;

   int checks = 0;
   int errors = 0;

   // Monitor state
   logic [7:0] bytes[$];
   int         xfer_cyc[$];
   logic [4:0] reg_s[$];
   logic [7:0] ram_s[$];
   int         cyc = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   logic       done_busy = 1'b0;
   int         stab_viol = 0;
   bit         hold_pend = 0;
   logic [7:0] held = '0;
   int         rdy_mode = 0; // 0 low, 1 high, 2 random 30%, 3 random 50%

   logic [31:0] regs[32];
   logic [31:0] ram[256];

   nnrv_dump_if tx();

   nnrv_dump dut (
      .i_clk      (clk),
      .i_rst      (rst_n),
      .i_start    (start),
      .o_busy     (busy),
      .o_done     (done),
      .o_reg_addr (reg_addr),
      .i_reg_data (reg_rdata),
      .o_ram_addr (ram_addr),
      .i_ram_data (ram_rdata),
      .tx         (tx)
   );

   always #5 clk = ~clk;

   // Read-port model: data follows the address by one cycle.
   always @(posedge clk) begin
      reg_rdata <= regs[reg_addr];
      ram_rdata <= ram[ram_addr];
   end

   always @(negedge clk) begin
      case (rdy_mode)
         1:       tx.tx_ready = 1'b1;
         2:       tx.tx_ready = ($urandom_range(0, 99) < 30);
         3:       tx.tx_ready = $urandom_range(0, 1) == 1;
         default: tx.tx_ready = 1'b0;
      endcase
   end

   // Byte-stream monitor: records transfers, address samples and done pulses.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         hold_pend = 0;
      end else begin
         if (hold_pend && !(tx.tx_valid && tx.tx_data == held)) stab_viol = stab_viol + 1;
         hold_pend = tx.tx_valid && !tx.tx_ready;
         held      = tx.tx_data;
         if (tx.tx_valid && tx.tx_ready) begin
            bytes.push_back(tx.tx_data);
            xfer_cyc.push_back(cyc);
         end
         if (busy && !tx.tx_valid) begin
            reg_s.push_back(reg_addr);
            ram_s.push_back(ram_addr);
         end
         if (done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = busy;
         end
      end
   end

   function automatic logic [7:0] exp_byte(int i);
      logic [31:0] w;
      int k, b;
      if (i == 0)   return 8'hA5;
      if (i == 257) return 8'h5A;
      k = (i - 1) / 4;
      b = (i - 1) % 4;
      w = (k < 32) ? 32'h1000_0000 + 32'(k) : 32'hCAFE_0000 + 32'(k - 32);
      return w[31 - 8*b -: 8];
   endfunction

   task automatic clear_mon();
      bytes.delete();
      xfer_cyc.delete();
      reg_s.delete();
      ram_s.delete();
      done_cnt  = 0;
      stab_viol = 0;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(output bit to);
      int n = 0;
      while (done_cnt == 0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      to = (done_cnt == 0);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rdy_mode = 3;
      repeat (6) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1));
         checks++;
         if ({busy, done, tx.tx_valid, tx.tx_data, reg_addr, ram_addr} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b valid=%b data=%h ra=%h ma=%h required all 0",
                     busy, done, tx.tx_valid, tx.tx_data, reg_addr, ram_addr);
         end
      end
      start = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      clear_mon();
      repeat (4) @(negedge clk);
      checks++;
      if ({busy, done, tx.tx_valid} !== 3'b000 || bytes.size() != 0) begin
         errors++;
         $display("FAIL reset_release busy=%b done=%b valid=%b bytes=%0d required idle",
                  busy, done, tx.tx_valid, bytes.size());
      end
   endtask

   task automatic test_full_frame();
      bit to;
      clear_mon();
      rdy_mode = 1;
      pulse_start();
      checks++;
      if (tx.tx_valid !== 1'b1 || tx.tx_data !== 8'hA5 || busy !== 1'b1) begin
         errors++;
         $display("FAIL header_latency valid=%b data=%h busy=%b required 1/a5/1", tx.tx_valid, tx.tx_data, busy);
      end
      wait_done(to);
      checks++;
      if (to) begin errors++; $display("FAIL full_timeout done_cnt=%0d required 1", done_cnt); end
      checks++;
      if (bytes.size() != 258) begin
         errors++; $display("FAIL full_len got %0d required 258", bytes.size());
      end else begin
         for (int i = 0; i < 258; i++) begin
            checks++;
            if (bytes[i] !== exp_byte(i)) begin
               errors++; $display("FAIL full_byte[%0d] got %h required %h", i, bytes[i], exp_byte(i));
            end
         end
         checks++;
         if (done_cyc != xfer_cyc[257] + 1 || done_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_timing done_cyc=%0d trl_cyc=%0d busy=%b required trl+1 and busy 0",
                     done_cyc, xfer_cyc[257], done_busy);
         end
         // HDR transfer, then 6 cycles per word (RD, WAIT, 4x SEND), then TRL.
         checks++;
         if (xfer_cyc[257] - xfer_cyc[0] != 385) begin
            errors++; $display("FAIL throughput span=%0d required 385", xfer_cyc[257] - xfer_cyc[0]);
         end
      end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL full_done_cnt got %0d required 1", done_cnt); end
   endtask

   task automatic test_addr_latency();
      bit to;
      clear_mon();
      rdy_mode = 1;
      pulse_start();
      wait_done(to);
      checks++;
      if (to || reg_s.size() != 128) begin
         errors++; $display("FAIL addr_samples got %0d timeout=%0d required 128", reg_s.size(), to);
      end else begin
         for (int i = 0; i < 128; i++) begin
            checks++;
            if (i < 64 && reg_s[i] !== 5'(i / 2)) begin
               errors++; $display("FAIL reg_addr[%0d] got %0d required %0d", i, reg_s[i], i / 2);
            end else if (i >= 64 && ram_s[i] !== 8'((i - 64) / 2)) begin
               errors++; $display("FAIL ram_addr[%0d] got %0d required %0d", i, ram_s[i], (i - 64) / 2);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit to;
      clear_mon();
      rdy_mode = 2;
      pulse_start();
      wait_done(to);
      rdy_mode = 1;
      checks++;
      if (to || bytes.size() != 258) begin
         errors++; $display("FAIL bp_len got %0d timeout=%0d required 258", bytes.size(), to);
      end else begin
         for (int i = 0; i < 258; i++) begin
            checks++;
            if (bytes[i] !== exp_byte(i)) begin
               errors++; $display("FAIL bp_byte[%0d] got %h required %h", i, bytes[i], exp_byte(i));
            end
         end
      end
      checks++;
      if (stab_viol != 0) begin errors++; $display("FAIL bp_stability violations=%0d required 0", stab_viol); end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt got %0d required 1", done_cnt); end
   endtask

   task automatic test_start_while_busy();
      int n = 0;
      clear_mon();
      rdy_mode = 1;
      pulse_start();
      while (bytes.size() < 50 && n < 1000) begin @(negedge clk); n++; end
      pulse_start();
      n = 0;
      while (!done && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (!done) begin errors++; $display("FAIL busy_no_done done=%b required 1", done); end
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if (bytes.size() != 258 || done_cnt != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_ignored bytes=%0d done_cnt=%0d busy=%b required 258/1/0", bytes.size(), done_cnt, busy);
      end else begin
         for (int i = 0; i < 258; i++) begin
            checks++;
            if (bytes[i] !== exp_byte(i)) begin
               errors++; $display("FAIL swb_byte[%0d] got %h required %h", i, bytes[i], exp_byte(i));
            end
         end
      end
   endtask

   task automatic test_reset_mid_dump();
      bit to;
      int n = 0;
      clear_mon();
      rdy_mode = 1;
      pulse_start();
      while (bytes.size() < 42 && n < 1000) begin @(negedge clk); n++; end
      checks++;
      if (tx.tx_valid !== 1'b1 || bytes.size() != 42) begin
         errors++; $display("FAIL mid_pos valid=%b bytes=%0d required 1/42", tx.tx_valid, bytes.size());
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, tx.tx_valid, tx.tx_data, reg_addr, ram_addr} !== 24'h0) begin
         errors++;
         $display("FAIL mid_reset busy=%b done=%b valid=%b data=%h ra=%h ma=%h required all 0",
                  busy, done, tx.tx_valid, tx.tx_data, reg_addr, ram_addr);
      end
      @(negedge clk) rst_n = 1'b1;
      clear_mon();
      repeat (5) @(negedge clk);
      checks++;
      if (bytes.size() != 0 || busy !== 1'b0 || done_cnt != 0) begin
         errors++;
         $display("FAIL mid_abort bytes=%0d busy=%b done_cnt=%0d required 0/0/0", bytes.size(), busy, done_cnt);
      end
      pulse_start();
      wait_done(to);
      checks++;
      if (to || bytes.size() != 258) begin
         errors++; $display("FAIL mid_refr_len got %0d timeout=%0d required 258", bytes.size(), to);
      end else begin
         for (int i = 0; i < 258; i++) begin
            checks++;
            if (bytes[i] !== exp_byte(i)) begin
               errors++; $display("FAIL mid_byte[%0d] got %h required %h", i, bytes[i], exp_byte(i));
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + 32'(k);
      for (int k = 0; k < 256; k++) ram[k] = (k < 32) ? 32'hCAFE_0000 + 32'(k) : 32'hDEAD_BEEF;
      test_reset();
      test_full_frame();
      test_addr_latency();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid_dump();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nnrv_dump.md
Name: nnrv_dump

Overview:
- Post-run state dump engine downstream of nnrv_top.
- On a start pulse it reads architectural state (register file, then data RAM), serialises every 32-bit word MSB-first into bytes, and streams them through a valid/ready byte interface to the UART transmitter.
- Gives on-silicon runs the same regs/ram result view the simulation log provides.

Parameters:
- NUM_REGS, 32: register-file words dumped, indices 0..NUM_REGS-1.
- RAM_WORDS, 32: data-RAM words dumped, word addresses 0..RAM_WORDS-1.
- RAM_AW, 8: width of the RAM word-address port.
- HDR_BYTE, 8'hA5: frame start marker.
- TRL_BYTE, 8'h5A: frame end marker.

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  single-cycle dump request.
- o_busy  out  1  high from accepted start until the trailer byte is transferred.
- o_done  out  1  one-cycle pulse in the cycle after the trailer transfer.
- o_reg_addr  out  5  register-file read index.
- i_reg_data  in  32  register read data, valid one cycle after o_reg_addr.
- o_ram_addr  out  RAM_AW  RAM word read address.
- i_ram_data  in  32  RAM read data, valid one cycle after o_ram_addr.
- o_tx_data  out  8  byte to transmit.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  sink accepts the byte; a transfer occurs when valid and ready are both high on a rising edge.

Behaviour:
- Reset (i_rst=0, async): state IDLE, all counters 0. o_busy=0, o_done=0, o_tx_valid=0, o_tx_data=0, o_reg_addr=0, o_ram_addr=0.
- Reset mid-dump aborts the frame immediately, with no trailer. After release the block waits in IDLE.
- FSM states: IDLE, HDR, RD, WAIT, SEND, TRL, DONE.
- IDLE: i_start=1 -> HDR. i_start is ignored in every other state.
- HDR: o_tx_valid=1, o_tx_data=HDR_BYTE. On transfer -> RD.
  - Header is visible on the cycle after i_start is sampled.
- RD: drive the address for the current word index w (0..NUM_REGS+RAM_WORDS-1).
  - w<NUM_REGS: o_reg_addr=w.
  - Otherwise: o_ram_addr=w-NUM_REGS.
  - Next state WAIT.
- WAIT: capture the selected read data into a 32-bit shift register, set byte counter=0 -> SEND. The address outputs hold their value through WAIT.
- SEND: o_tx_valid=1, o_tx_data=shreg[31:24].
  - On each transfer: shift left by 8, increment byte counter.
  - After the 4th transfer: w==last -> TRL, else w++ and -> RD.
- TRL: o_tx_valid=1, o_tx_data=TRL_BYTE. On transfer -> DONE.
- DONE: o_done=1 for exactly one cycle -> IDLE.
- o_busy=1 in HDR through TRL inclusive. It is 0 in DONE and IDLE.
- Valid/ready rules:
  - Once o_tx_valid rises, o_tx_valid and o_tx_data stay stable until a transfer.
  - o_tx_valid never drops without a transfer, except on reset.
  - o_tx_valid is 0 in RD and WAIT (2-cycle bubble per word).
- Frame length: 2 + 4*(NUM_REGS+RAM_WORDS) bytes, which is 258 with the defaults.
- Word index counter width: clog2(NUM_REGS+RAM_WORDS)+1. It must not wrap before the final compare.
- i_ready held high continuously gives throughput of 1 byte/cycle within a word.
- i_tx_ready high while o_tx_valid is low has no effect.
- Register index 0 is dumped as returned by the register file. No forcing to zero.
- i_start asserted in the DONE cycle is ignored.

Decomposition:
- Shared package: FSM state encoding (7 states, 3-bit) and the default HDR/TRL byte constants.
- No sub-module. Optional: a separate nnrv_dump_ser (32-bit word to 4-byte valid/ready serialiser) if the UART path reuses it. Otherwise everything stays in one module.

Test Plan:
- Reset values: hold i_rst=0 with random inputs -> o_busy=0, o_done=0, o_tx_valid=0, o_tx_data=0, addresses 0. Release -> still IDLE, no output.
- Full frame, sink always ready: regs[k]=32'h1000_0000+k, ram[k]=32'hCAFE_0000+k, pulse i_start.
  - Bytes are A5, 10,00,00,00, 10,00,00,01, ..., CA,FE,00,1F, 5A.
  - 258 transfers total. o_done pulses once, one cycle after the 5A transfer. o_busy falls in that same cycle.
- Backpressure: i_tx_ready random ~30% duty -> identical byte sequence to the full-frame case. o_tx_data never changes while valid=1 and ready=0.
- Address/latency check: monitor o_reg_addr = 0..31 then o_ram_addr = 0..31, each held for the RD+WAIT cycles. The read-data model with 1-cycle latency yields correct bytes.
- Start while busy: pulse i_start at byte 50 and again in the DONE cycle -> exactly one frame of 258 bytes and one o_done.
- Reset mid-dump: assert i_rst=0 during SEND of word 10 -> outputs at reset values immediately. Release, pulse i_start -> a fresh complete frame starting with A5 and register 0.
